// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
// Contents: state_t (IDLE/RUN/DONE, 2-bit), cnt_w() bit-counter width helper.
package bit_serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter is wide enough to hold WIDTH; it never counts past WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// rtl/bit_serial_adder_if.sv - operand/result handshake bundle for bit_serial_adder
// Signals: in_valid/in_ready/a/b/cin (operand side), out_valid/out_ready/sum/cout (result side),
//          ovf only when BIT_SERIAL_ADD_OVF_EN is defined.
// Modports: master (operand source / result sink), slave (the adder).
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef BIT_SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/bit_serial_adder_full_adder.sv
// rtl/bit_serial_adder_full_adder.sv - combinational 1-bit full-adder cell
// Ports: a, b, cin (in) -> s, cout (out).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - bit-serial WIDTH-bit adder, one bit pair per cycle LSB first
// Ports: clk, rst_n (sync, active-low), bus (bit_serial_adder_if.slave).
// Optional: BIT_SERIAL_ADD_OVF_EN adds the registered signed-overflow output bus.ovf.
module bit_serial_adder
  import bit_serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serial_adder_if.slave   bus
);

  localparam int               CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt, sum_q;
  logic [CNT_W-1:0] cnt;
  logic             carry, cout_q;
  logic             s_cell, c_cell;
  logic             last_bit;
`ifdef BIT_SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_cell),
    .cout (c_cell)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
  // Shifting the WIDTH+1 concatenation keeps this legal for WIDTH=1.
  assign sum_nxt  = WIDTH'({s_cell, sum_sh} >> 1);
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
`ifdef BIT_SERIAL_ADD_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sh <= sum_nxt;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= c_cell;
          if (last_bit) begin
            // Result registers change only here, so they hold through DONE and IDLE.
            sum_q  <= sum_nxt;
            cout_q <= c_cell;
`ifdef BIT_SERIAL_ADD_OVF_EN
            // carry is the carry into the MSB on this final cycle.
            ovf_q  <= carry ^ c_cell;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef BIT_SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - self-checking bench for bit_serial_adder (WIDTH 8, 1 and 64)
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0: WIDTH=8, 1: WIDTH=1, 2: WIDTH=64
  logic        iv[3], ci[3], ordy[3];
  logic [63:0] av[3], bv[3];
  logic        ir[3], ov[3], co[3];
  logic [63:0] sm[3];

  int n_checks = 0;
  int n_fail   = 0;

  bit_serial_adder_if #(.WIDTH(8))  if8 ();
  bit_serial_adder_if #(.WIDTH(1))  if1 ();
  bit_serial_adder_if #(.WIDTH(64)) if64 ();

  assign if8.in_valid  = iv[0];   assign if8.a  = av[0][7:0];  assign if8.b  = bv[0][7:0];
  assign if8.cin       = ci[0];   assign if8.out_ready  = ordy[0];
  assign ir[0] = if8.in_ready;    assign ov[0] = if8.out_valid;
  assign sm[0] = 64'(if8.sum);    assign co[0] = if8.cout;

  assign if1.in_valid  = iv[1];   assign if1.a  = av[1][0:0];  assign if1.b  = bv[1][0:0];
  assign if1.cin       = ci[1];   assign if1.out_ready  = ordy[1];
  assign ir[1] = if1.in_ready;    assign ov[1] = if1.out_valid;
  assign sm[1] = 64'(if1.sum);    assign co[1] = if1.cout;

  assign if64.in_valid = iv[2];   assign if64.a = av[2];       assign if64.b = bv[2];
  assign if64.cin      = ci[2];   assign if64.out_ready = ordy[2];
  assign ir[2] = if64.in_ready;   assign ov[2] = if64.out_valid;
  assign sm[2] = if64.sum;        assign co[2] = if64.cout;

`ifdef BIT_SERIAL_ADD_OVF_EN
  logic ovf8;
  assign ovf8 = if8.ovf;
`endif

  bit_serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  bit_serial_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  bit_serial_adder #(.WIDTH(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

  function automatic int wof(input int k);
    return (k == 0) ? 8 : (k == 1) ? 1 : 64;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // One full operation: offer operands, check latency/result, optionally back-pressure, then drain.
  task automatic do_op(input int k, input logic [63:0] a_in, input logic [63:0] b_in,
                       input logic cin, input int hold, input bit noise, output longint acc_t);
    int          w, n;
    logic [63:0] m, a, b, es;
    logic [64:0] full;
    logic        ec;
    w    = wof(k);
    m    = mask_of(w);
    a    = a_in & m;
    b    = b_in & m;
    full = {1'b0, a} + {1'b0, b} + 65'(cin);
    es   = full[63:0] & m;
    ec   = full[w];
    acc_t = 0;

    iv[k] = 1'b1; av[k] = a; bv[k] = b; ci[k] = cin;
    n = 0;
    while (ir[k] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (ir[k] !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout w=%0d in_ready=%b required 1", w, ir[k]);
      iv[k] = 1'b0;
      return;
    end
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    iv[k] = 1'b0;
    n = 0;
    while (ov[k] !== 1'b1 && n < 200) begin
      if (noise) begin
        iv[k] = 1'($urandom); av[k] = {$urandom, $urandom}; bv[k] = {$urandom, $urandom};
        ci[k] = 1'($urandom); ordy[k] = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    ordy[k] = 1'b0;
    n_checks++;
    if (n !== w) begin
      n_fail++;
      $display("FAIL latency w=%0d got %0d cycles required %0d", w, n, w);
    end
    n_checks++;
    if (sm[k] !== es || co[k] !== ec) begin
      n_fail++;
      $display("FAIL result w=%0d a=%h b=%h cin=%b got sum=%h cout=%b required sum=%h cout=%b",
               w, a, b, cin, sm[k], co[k], es, ec);
    end

    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        iv[k] = 1'($urandom); av[k] = {$urandom, $urandom}; bv[k] = {$urandom, $urandom};
      end
      @(negedge clk);
      n_checks++;
      if (ov[k] !== 1'b1 || ir[k] !== 1'b0 || sm[k] !== es || co[k] !== ec) begin
        n_fail++;
        $display("FAIL hold w=%0d cyc=%0d got ov=%b ir=%b sum=%h cout=%b required ov=1 ir=0 sum=%h cout=%b",
                 w, i, ov[k], ir[k], sm[k], co[k], es, ec);
      end
    end

    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    n_checks++;
    if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || sm[k] !== es || co[k] !== ec) begin
      n_fail++;
      $display("FAIL drain w=%0d got ov=%b ir=%b sum=%h cout=%b required ov=0 ir=1 sum=%h cout=%b",
               w, ov[k], ir[k], sm[k], co[k], es, ec);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || sm[k] !== 64'd0 || co[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state k=%0d got ir=%b ov=%b sum=%h cout=%b required ir=1 ov=0 sum=0 cout=0",
                 k, ir[k], ov[k], sm[k], co[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry();
    longint t;
    do_op(0, 64'hFF, 64'h01, 1'b0, 0, 0, t);
    do_op(0, 64'hFF, 64'h00, 1'b1, 0, 0, t);
  endtask

  task automatic test_basic();
    longint t;
    do_op(0, 64'h0F, 64'h01, 1'b0, 0, 0, t);
    do_op(1, 64'h1, 64'h1, 1'b1, 0, 0, t);
    do_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 0, t);
  endtask

  task automatic test_backpressure();
    longint t;
    do_op(0, 64'h3C, 64'h21, 1'b1, 20, 1, t);
  endtask

  task automatic test_reset_mid();
    longint t;
    iv[0] = 1'b1; av[0] = 64'h5A; bv[0] = 64'h33; ci[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || sm[0] !== 64'd0 || co[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got ir=%b ov=%b sum=%h cout=%b required ir=1 ov=0 sum=0 cout=0",
               ir[0], ov[0], sm[0], co[0]);
    end
    do_op(0, 64'h5A, 64'h33, 1'b0, 0, 0, t);
  endtask

  task automatic test_back_to_back();
    longint t_prev, t;
    for (int k = 0; k < 2; k++) begin
      do_op(k, 64'($urandom), 64'($urandom), 1'($urandom), 0, 0, t_prev);
      for (int i = 0; i < 4; i++) begin
        do_op(k, 64'($urandom), 64'($urandom), 1'($urandom), 0, 0, t);
        n_checks++;
        if (t - t_prev != longint'((wof(k) + 2) * 10)) begin
          n_fail++;
          $display("FAIL op_period w=%0d got %0d ns required %0d ns", wof(k), t - t_prev, (wof(k) + 2) * 10);
        end
        t_prev = t;
      end
    end
  endtask

`ifdef BIT_SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    logic [7:0] ta[3], tb[3];
    logic       te[3];
    longint     t;
    ta = '{8'h7F, 8'h80, 8'h01};
    tb = '{8'h01, 8'h80, 8'h01};
    for (int i = 0; i < 3; i++) begin
      do_op(0, 64'(ta[i]), 64'(tb[i]), 1'b0, 0, 0, t);
      te[i] = (ta[i][7] == tb[i][7]) && (8'(ta[i] + tb[i]) >> 7 != 8'(ta[i][7]));
      n_checks++;
      if (ovf8 !== te[i]) begin
        n_fail++;
        $display("FAIL ovf a=%h b=%h got %b required %b", ta[i], tb[i], ovf8, te[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int     nops[3];
    longint t;
    nops = '{300, 400, 150};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < nops[k]; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_op(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
              int'($urandom_range(0, 3)), 1, t);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ci[k] = 1'b0; ordy[k] = 1'b0; av[k] = '0; bv[k] = '0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_carry();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef BIT_SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
